inst_issuer: RTL and testbench

- Instruction issue unit that drives the decode stage's instruction-input interface (opcode, src1, src2, dst, imm, instv).
- Buffers packed instruction words from a host/loader in a FIFO.
- Presents one instruction at a time from a registered issue slot.
- Holds the slot while decode reports stalled; flushes on decode's internal_reset.

---
 rtl/inst_issuer.sv | 97 +++++++++
 tb/tb_inst_issuer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_issuer.sv
// rtl/inst_issuer.sv - instruction FIFO plus registered issue slot feeding the decode stage
module inst_issuer #(
    parameter int OP_W   = 4,
    parameter int ADR_W  = 5,
    parameter int IMM_W  = 16,
    parameter int DEPTH  = 8,
    parameter int INST_W = OP_W + 3 * ADR_W + IMM_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [INST_W-1:0]          push_inst,
    input  logic                       run,
    input  logic                       stalled,
    input  logic                       internal_reset,
    output logic [OP_W-1:0]            opcode,
    output logic [ADR_W-1:0]           src1,
    output logic [ADR_W-1:0]           src2,
    output logic [ADR_W-1:0]           dst,
    output logic [IMM_W-1:0]           imm,
    output logic                       instv,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                issued_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [INST_W-1:0] slot_q, slot_d;
    logic              instv_q, instv_d;
    logic [15:0]       issued_q, issued_d;
    logic              adv, do_push, do_pop, accept;

    // Full/empty come from the registered count only, so a same-cycle pop never frees a slot for a push.
    assign push_ready = (count_q < DEPTH_C);
    assign adv        = !instv_q || !stalled;
    assign do_push    = push_valid && push_ready && !internal_reset;
    assign do_pop     = adv && run && (count_q != '0) && !internal_reset;
    assign accept     = instv_q && !stalled && !internal_reset;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        slot_d   = do_pop  ? mem_q[rd_ptr_q]   : slot_q;
        instv_d  = adv     ? do_pop            : instv_q;
        issued_d = accept  ? issued_q + 16'd1  : issued_q;
        if (internal_reset) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            instv_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            slot_q   <= '0;
            instv_q  <= 1'b0;
            issued_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            slot_q   <= slot_d;
            instv_q  <= instv_d;
            issued_q <= issued_d;
        end
    end

    // Storage array needs no reset: occupancy is tracked entirely by count and pointers.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_inst;
    end

    assign opcode       = slot_q[INST_W-1 -: OP_W];
    assign dst          = slot_q[IMM_W+3*ADR_W-1 -: ADR_W];
    assign src1         = slot_q[IMM_W+2*ADR_W-1 -: ADR_W];
    assign src2         = slot_q[IMM_W+ADR_W-1 -: ADR_W];
    assign imm          = slot_q[IMM_W-1:0];
    assign instv        = instv_q;
    assign fifo_count   = count_q;
    assign issued_count = issued_q;
endmodule

// File: tb/tb_inst_issuer.sv
// tb/tb_inst_issuer.sv - randomized and directed bench for inst_issuer against a queue model
module tb_inst_issuer;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [34:0] push_inst = '0;
    logic        run = 1'b0;
    logic        stalled = 1'b0;
    logic        internal_reset = 1'b0;
    logic [3:0]  opcode;
    logic [4:0]  src1, src2, dst;
    logic [15:0] imm;
    logic        instv;
    logic [3:0]  fifo_count;
    logic [15:0] issued_count;

    inst_issuer dut (
        .clock(clock), .reset(reset), .push_valid(push_valid), .push_ready(push_ready),
        .push_inst(push_inst), .run(run), .stalled(stalled), .internal_reset(internal_reset),
        .opcode(opcode), .src1(src1), .src2(src2), .dst(dst), .imm(imm), .instv(instv),
        .fifo_count(fifo_count), .issued_count(issued_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int dut_acc = 0;

    logic [34:0] m_fifo[$];
    logic        m_v = 1'b0;
    logic [34:0] m_w = '0;
    logic [15:0] m_iss = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [34:0] mk(input logic [3:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [15:0] im);
        return {op, d, s1, s2, im};
    endfunction

    function automatic logic [34:0] rnd_word();
        logic [34:0] w;
        w = {$urandom(), $urandom()};
        return w;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_v   = 1'b0;
        m_iss = '0;
    endtask

    // Behavioural rules applied once per clock edge from the inputs present at that edge.
    task automatic model_edge();
        bit push_ok;
        if (internal_reset) begin
            m_v = 1'b0;
            m_fifo.delete();
        end else begin
            push_ok = push_valid && (m_fifo.size() < DEPTH);
            if (m_v && !stalled) m_iss = m_iss + 16'd1;
            if (!m_v || !stalled) begin
                if (run && m_fifo.size() > 0) begin
                    m_w = m_fifo.pop_front();
                    m_v = 1'b1;
                end else begin
                    m_v = 1'b0;
                end
            end
            if (push_ok) m_fifo.push_back(push_inst);
        end
    endtask

    task automatic compare_all();
        chk("instv", 64'(instv), 64'(m_v));
        chk("fifo_count", 64'(fifo_count), 64'(m_fifo.size()));
        chk("push_ready", 64'(push_ready), 64'(m_fifo.size() < DEPTH));
        chk("issued_count", 64'(issued_count), 64'(m_iss));
        if (m_v) chk("slot", 64'({opcode, dst, src1, src2, imm}), 64'(m_w));
    endtask

    task automatic step();
        if (instv && !stalled && !internal_reset) dut_acc++;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        push_valid = 1'b0;
        run = 1'b0;
        stalled = 1'b0;
        internal_reset = 1'b0;
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before the next edge.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("rst_fields", 64'({opcode, dst, src1, src2, imm}), 64'd0);
        chk("rst_instv", 64'(instv), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_issued", 64'(issued_count), 64'd0);
        #1 reset = 1'b0;
    endtask

    logic [34:0] w1;
    int cyc;

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        compare_all();
        chk("init_ready", 64'(push_ready), 64'd1);
        #2 reset = 1'b0;

        // single instruction latency
        w1 = mk(4'h1, 5'd5, 5'd3, 5'd4, 16'h00AB);
        run = 1'b1;
        push_valid = 1'b1;
        push_inst = w1;
        step();
        push_valid = 1'b0;
        chk("t1_instv_n", 64'(instv), 64'd0);
        step();
        chk("t1_instv_n1", 64'(instv), 64'd1);
        chk("t1_word", 64'({opcode, dst, src1, src2, imm}), 64'(w1));
        step();
        chk("t1_issued", 64'(issued_count), 64'd1);
        chk("t1_instv_after", 64'(instv), 64'd0);

        // stall holds the slot
        pulse_reset();
        push_valid = 1'b1;
        push_inst = mk(4'h2, 5'd1, 5'd2, 5'd3, 16'h1111);
        w1 = push_inst;
        step();
        push_inst = mk(4'h3, 5'd4, 5'd5, 5'd6, 16'h2222);
        step();
        stalled = 1'b1;
        push_inst = mk(4'h4, 5'd7, 5'd8, 5'd9, 16'h3333);
        for (int i = 0; i < 4; i++) begin
            step();
            push_valid = 1'b0;
            chk("t2_hold", 64'({opcode, dst, src1, src2, imm}), 64'(w1));
            chk("t2_instv", 64'(instv), 64'd1);
            chk("t2_count", 64'(fifo_count), 64'd2);
        end
        stalled = 1'b0;
        repeat (3) step();
        chk("t2_issued", 64'(issued_count), 64'd3);
        chk("t2_instv_end", 64'(instv), 64'd0);

        // fill to DEPTH with run low, overflow push ignored
        pulse_reset();
        idle_inputs();
        push_valid = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_inst = mk(4'(i), 5'(i), 5'(i + 1), 5'(i + 2), 16'(16'hA000 + i));
            step();
        end
        push_valid = 1'b0;
        chk("t3_full", 64'(fifo_count), 64'd8);
        chk("t3_ready", 64'(push_ready), 64'd0);
        run = 1'b1;
        step();
        chk("t3_ready_pop", 64'(push_ready), 64'd1);
        repeat (10) step();
        chk("t3_issued", 64'(issued_count), 64'd8);
        chk("t3_instv", 64'(instv), 64'd0);

        // internal_reset flush with a concurrent push
        pulse_reset();
        idle_inputs();
        push_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_inst = rnd_word();
            step();
        end
        push_valid = 1'b0;
        run = 1'b1;
        step();
        chk("t4_pre_count", 64'(fifo_count), 64'd3);
        internal_reset = 1'b1;
        push_valid = 1'b1;
        push_inst = rnd_word();
        step();
        internal_reset = 1'b0;
        push_valid = 1'b0;
        chk("t4_instv", 64'(instv), 64'd0);
        chk("t4_count", 64'(fifo_count), 64'd0);
        chk("t4_issued", 64'(issued_count), 64'd0);
        repeat (3) step();
        chk("t4_absent", 64'(instv), 64'd0);

        // async reset mid-operation
        idle_inputs();
        push_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_inst = rnd_word();
            step();
        end
        push_valid = 1'b0;
        run = 1'b1;
        stalled = 1'b1;
        step();
        chk("t5_pre_instv", 64'(instv), 64'd1);
        chk("t5_pre_count", 64'(fifo_count), 64'd5);
        pulse_reset();

        // randomized mix
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            push_valid = ($urandom_range(1, 0) == 1);
            push_inst = rnd_word();
            run = ($urandom_range(3, 0) != 0);
            stalled = ($urandom_range(2, 0) == 0);
            internal_reset = ($urandom_range(31, 0) == 0);
            step();
        end

        // long back-to-back stream
        idle_inputs();
        pulse_reset();
        run = 1'b1;
        dut_acc = 0;
        cyc = 0;
        push_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            push_inst = mk(4'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()), 16'(i));
            step();
            cyc++;
        end
        push_valid = 1'b0;
        for (int i = 0; i < 50 && (instv || fifo_count != 0); i++) begin
            step();
            cyc++;
        end
        chk("t6_drained", 64'(instv || fifo_count != 0), 64'd0);
        chk("t6_accepted", 64'(dut_acc), 64'd70000);
        chk("t6_issued", 64'(issued_count), 64'd4464);
        chk("t6_throughput", 64'(cyc <= 70003), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
